stream_mux: RTL and testbench

Two-to-one AXI-stream-style multiplexer that forwards one of two valid/ready input streams to a single output stream. The active input is chosen by a select line. An optional registered output stage (skid buffer) cuts combinational paths for timing closure. Sideband bits such as TLAST are carried as the MSBs of the data word, so the block is payload-agnostic. It sits between stream sources (e.g. DMA or pattern generators) and a downstream consumer.

---
 rtl/stream_mux.sv | 92 +++++++++
 tb/tb_stream_mux.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux.sv
// Two-to-one valid/ready stream multiplexer. OUT_BUF="TRUE" adds a main/skid
// register pair so in_ready has no combinational path from out_ready.
module stream_mux #(
  parameter int    DATA_WIDTH = 32,
  parameter string OUT_BUF    = "FALSE"
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_select,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic                  in_valid_0,
  output logic                  in_ready_0,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic                  in_valid_1,
  output logic                  in_ready_1,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [DATA_WIDTH-1:0] w_in_data;
  logic                  w_in_valid;
  logic                  w_in_ready;
  logic                  r_run;

  assign w_in_data  = in_select ? in_data_1  : in_data_0;
  assign w_in_valid = in_select ? in_valid_1 : in_valid_0;
  assign in_ready_0 = w_in_ready & ~in_select;
  assign in_ready_1 = w_in_ready &  in_select;

  // Run flag: clears asynchronously, sets on the first edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  generate
    if (OUT_BUF == "TRUE") begin : g_buf
      logic [DATA_WIDTH-1:0] r_main_data;
      logic                  r_main_valid;
      logic [DATA_WIDTH-1:0] r_skid_data;
      logic                  r_skid_valid;
      logic                  w_accept;
      logic                  w_drain;

      assign w_in_ready = r_run & ~r_skid_valid;
      assign w_accept   = w_in_valid & w_in_ready;
      assign w_drain    = r_main_valid & out_ready;
      assign out_valid  = r_main_valid;
      assign out_data   = r_main_data;

      // Main/skid pair: main feeds the output, skid catches the word accepted while main is stalled.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_main_data  <= '0;
          r_main_valid <= 1'b0;
          r_skid_data  <= '0;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          if (!r_main_valid || out_ready) begin
            r_main_valid <= 1'b1;
            if (r_skid_valid) begin
              r_main_data <= r_skid_data;
              r_skid_data <= w_in_data;
            end else begin
              r_main_data <= w_in_data;
            end
          end else begin
            r_skid_data  <= w_in_data;
            r_skid_valid <= 1'b1;
          end
        end else if (w_drain) begin
          if (r_skid_valid) begin
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
          end else begin
            r_main_valid <= 1'b0;
          end
        end
      end
    end else begin : g_pass
      // Pass-through is gated until the run flag is up so reset forces everything low.
      assign w_in_ready = r_run & out_ready;
      assign out_valid  = r_run & w_in_valid;
      assign out_data   = {DATA_WIDTH{r_run}} & w_in_data;
    end
  endgenerate

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench: one pass-through and one buffered stream_mux at DATA_WIDTH=33,
// exercised one after the other against the source word sequence.
module tb_stream_mux;
  localparam int DW = 33;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rstn [2];
  logic          sel  [2];
  logic [DW-1:0] d0   [2];
  logic [DW-1:0] d1   [2];
  logic          v0   [2];
  logic          v1   [2];
  logic          r0   [2];
  logic          r1   [2];
  logic [DW-1:0] od   [2];
  logic          ov   [2];
  logic          ordy [2];

  stream_mux #(.DATA_WIDTH(DW), .OUT_BUF("FALSE")) u_pass (
    .clock(clock), .reset_n(rstn[0]), .in_select(sel[0]),
    .in_data_0(d0[0]), .in_valid_0(v0[0]), .in_ready_0(r0[0]),
    .in_data_1(d1[0]), .in_valid_1(v1[0]), .in_ready_1(r1[0]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]));

  stream_mux #(.DATA_WIDTH(DW), .OUT_BUF("TRUE")) u_buf (
    .clock(clock), .reset_n(rstn[1]), .in_select(sel[1]),
    .in_data_0(d0[1]), .in_valid_0(v0[1]), .in_ready_0(r0[1]),
    .in_data_1(d1[1]), .in_valid_1(v1[1]), .in_ready_1(r1[1]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]));

  int            act = 0;
  int            checks = 0;
  int            passed = 0;
  int            rcvd = 0;
  int            inflight = 0;
  bit            mon_en = 1'b0;
  int            rdy_mode = 0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s (OUT_BUF=%s): got %h, expected %h", name, act ? "TRUE" : "FALSE", got, want);
  endtask

  function automatic logic sel_ready();
    return sel[act] ? r1[act] : r0[act];
  endfunction

  task automatic set_sel_input(input logic [DW-1:0] w, input logic v);
    if (sel[act]) begin d1[act] = w; v1[act] = v; end
    else          begin d0[act] = w; v0[act] = v; end
  endtask

  // Advance one cycle, then drive junk on the unselected input.
  task automatic tick();
    @(posedge clock); #1;
    if (sel[act]) begin v0[act] = 1'($urandom_range(0, 1)); d0[act] = {1'($urandom_range(0, 1)), $urandom}; end
    else          begin v1[act] = 1'($urandom_range(0, 1)); d1[act] = {1'($urandom_range(0, 1)), $urandom}; end
  endtask

  task automatic send(input logic [DW-1:0] w, input bit stalls);
    bit acc;
    int n;
    if (stalls && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) tick();
    set_sel_input(w, 1'b1);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 1000) begin
      @(negedge clock);
      acc = sel_ready();
      tick();
      n++;
    end
    set_sel_input(w, 1'b0);
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: word %h not accepted, required accept within 1000 cycles", w);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  // Reference: the output sequence is the selected source's word list, last bit on the final word.
  task automatic stream(input logic s, input int cnt, input logic [31:0] start,
                        input logic [31:0] step, input bit stalls, input string name);
    int base;
    logic [DW-1:0] w;
    sel[act] = s;
    base = rcvd;
    for (int i = 0; i < cnt; i++) begin
      w = {1'(i == cnt - 1), 32'(start + 32'(i) * step)};
      exp_q.push_back(w);
    end
    for (int i = 0; i < cnt; i++) begin
      w = {1'(i == cnt - 1), 32'(start + 32'(i) * step)};
      send(w, stalls);
    end
    wait_drain();
    check(name, DW'(rcvd - base), DW'(cnt));
  endtask

  // Sink ready driver: 0 constant high, 1 random 1-5 cycle stalls, 2 held low.
  initial begin
    int stall = 0;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    forever begin
      @(posedge clock); #2;
      case (rdy_mode)
        2: ordy[act] = 1'b0;
        1: begin
          if (stall > 0) begin ordy[act] = 1'b0; stall--; end
          else if ($urandom_range(0, 2) == 0) begin ordy[act] = 1'b0; stall = $urandom_range(1, 5) - 1; end
          else ordy[act] = 1'b1;
        end
        default: ordy[act] = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold/occupancy rules.
  always @(negedge clock) begin : mon
    bit in_acc;
    bit out_acc;
    int nxt;
    logic [DW-1:0] want;
    if (!mon_en || !rstn[act]) begin
      inflight   <= 0;
      prev_stall <= 1'b0;
    end else begin
      check("unselected_ready", sel[act] ? r0[act] : r1[act], '0);
      in_acc  = sel[act] ? (v1[act] && r1[act]) : (v0[act] && r0[act]);
      out_acc = ov[act] && ordy[act];
      if (prev_stall) begin
        check("hold_valid", ov[act], 1);
        check("hold_data", od[act], prev_d);
      end
      if (out_acc) begin
        rcvd <= rcvd + 1;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL extra_word: got %h, expected no output", od[act]);
        end else begin
          want = exp_q.pop_front();
          check("out_data", od[act], want);
        end
      end
      nxt = inflight + int'(in_acc) - int'(out_acc);
      check("in_flight_bound", DW'(nxt >= 0 && nxt <= (act ? 2 : 0)), 1);
      inflight   <= nxt;
      prev_stall <= ov[act] && !ordy[act];
      prev_d     <= od[act];
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] w;
    bit acc;
    int base;
    for (int m = 0; m < 2; m++) begin
      rstn[m] = 1'b0; sel[m] = 1'b0;
      d0[m] = 33'h1_dead_beef; v0[m] = 1'b1;
      d1[m] = '0; v1[m] = 1'b0;
    end
    repeat (3) @(posedge clock);
    #3;
    for (int m = 0; m < 2; m++) begin
      act = m;
      check("reset_out_valid", ov[m], 0);
      check("reset_out_data", od[m], 0);
      check("reset_ready_0", r0[m], 0);
      check("reset_ready_1", r1[m], 0);
      v0[m] = 1'b0; d0[m] = '0;
    end
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    for (int m = 0; m < 2; m++) begin
      act = m;
      rdy_mode = 0;
      @(posedge clock); #1;
      mon_en = 1'b1;

      stream(1'b1, 11132, 32'hf2f10000, 32'h01010000, 1'b0, "long_stream_count");

      rdy_mode = 1;
      stream(1'b0, 25, 32'h00000201, 32'h00000101, 1'b1, "stall_stream_count");
      rdy_mode = 0;
      repeat (2) tick();

      // Back-pressure: out_ready held low while the source keeps offering words.
      sel[act] = 1'b0;
      base = rcvd;
      for (int i = 0; i < 6; i++) exp_q.push_back({1'(i == 5), 32'h0a000000 + 32'(i)});
      rdy_mode = 2;
      fork
        for (int i = 0; i < 6; i++) send({1'(i == 5), 32'h0a000000 + 32'(i)}, 1'b0);
        begin
          repeat (5) @(posedge clock);
          #3;
          check("bp_ready_low", sel_ready(), 0);
          rdy_mode = 0;
        end
      join
      wait_drain();
      check("bp_count", DW'(rcvd - base), DW'(6));

      // Latency: single word with out_ready high.
      w = {1'b1, 32'h5a5a0001 + 32'(m)};
      exp_q.push_back(w);
      set_sel_input(w, 1'b1);
      #1;
      check("lat_before_edge_valid", ov[act], act ? 0 : 1);
      if (act == 0) check("lat_same_cycle_data", od[act], w);
      @(negedge clock);
      acc = sel_ready();
      check("lat_ready", acc, 1);
      @(posedge clock); #1;
      set_sel_input(w, 1'b0);
      if (act == 1) begin
        check("lat_one_cycle_valid", ov[act], 1);
        check("lat_one_cycle_data", od[act], w);
      end
      wait_drain();

      // Reset mid-stream with words pending, then resume with a fresh stream.
      rdy_mode = 2;
      set_sel_input({1'b0, 32'hbad0bad0}, 1'b1);
      repeat (3) tick();
      #2;
      mon_en = 1'b0;
      rstn[act] = 1'b0;
      #1;
      check("midrst_out_valid", ov[act], 0);
      check("midrst_ready_0", r0[act], 0);
      check("midrst_ready_1", r1[act], 0);
      set_sel_input('0, 1'b0);
      repeat (2) @(negedge clock);
      #2;
      rstn[act] = 1'b1;
      rdy_mode = 0;
      tick();
      mon_en = 1'b1;
      stream(1'b0, 10, 32'h00c00000, 32'h00000003, 1'b0, "post_reset_count");

      mon_en = 1'b0;
      v0[m] = 1'b0;
      v1[m] = 1'b0;
      repeat (2) tick();
      v0[m] = 1'b0;
      v1[m] = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
